// File: rtl/uart_tx_sched_pkg.sv
// Shared types and defaults for the round-robin UART transmit scheduler.
package uart_tx_sched_pkg;

    localparam int DBIT_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        ACK
    } sched_state_t;

endpackage

// File: rtl/uart_tx_sched_if.sv
// Client/UART-facing signal bundle of the transmit scheduler.
interface uart_tx_sched_if
    import uart_tx_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int DBIT  = DBIT_DEFAULT
);

    logic [N_REQ-1:0]      req;
    logic [N_REQ*DBIT-1:0] req_data;
    logic [N_REQ-1:0]      gnt;
    logic [N_REQ-1:0]      ack;
    logic                  err;
    logic                  busy;
    logic [DBIT-1:0]       uart_din;
    logic                  uart_tx_start;
    logic                  uart_tx_done;

    // master: requesters plus the uart; slave: the scheduler itself
    modport master (
        output req, req_data, uart_tx_done,
        input  gnt, ack, err, busy, uart_din, uart_tx_start
    );

    modport slave (
        input  req, req_data, uart_tx_done,
        output gnt, ack, err, busy, uart_din, uart_tx_start
    );

endinterface

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] win
);

    always_comb begin
        int  idx;
        logic found;
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!found && req[idx]) begin
                win[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one UART transmitter among N_REQ byte requesters with round-robin
// arbitration and a watchdog that aborts frames whose done tick never arrives.
module uart_tx_sched
    import uart_tx_sched_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int DBIT        = DBIT_DEFAULT,
    parameter int TIMEOUT_CYC = 524288
) (
    input logic            clk,
    input logic            rst,
    uart_tx_sched_if.slave bus
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int WD_W  = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYC - 1);

    sched_state_t     state;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] gnt_idx;
    logic [PTR_W-1:0] next_ptr;
    logic [N_REQ-1:0] win;
    logic [DBIT-1:0]  win_data;
    logic [WD_W-1:0]  wd;
    logic [WD_W-1:0]  wd_inc;

    logic [N_REQ-1:0] gnt_q;
    logic [N_REQ-1:0] ack_q;
    logic             err_q;
    logic             busy_q;
    logic [DBIT-1:0]  din_q;
    logic             start_q;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .req (bus.req),
        .ptr (ptr),
        .win (win)
    );

    always_comb begin
        win_data = '0;
        gnt_idx  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win[i])   win_data = win_data | bus.req_data[i*DBIT +: DBIT];
            if (gnt_q[i]) gnt_idx  = PTR_W'(i);
        end
    end

    assign next_ptr = (gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
    assign wd_inc   = wd + WD_W'(1);

    // Abort fires when the incremented count reaches TIMEOUT_CYC-1, so the
    // ack lands exactly TIMEOUT_CYC cycles after the START cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            gnt_q   <= '0;
            ack_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            din_q   <= '0;
            start_q <= 1'b0;
            ptr     <= '0;
            wd      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        gnt_q   <= win;
                        din_q   <= win_data;
                        start_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state   <= START;
                    end
                end
                START: begin
                    start_q <= 1'b0;
                    wd      <= '0;
                    state   <= WAIT;
                end
                WAIT: begin
                    if (bus.uart_tx_done) begin
                        ack_q <= gnt_q;
                        err_q <= 1'b0;
                        state <= ACK;
                    end else if (wd_inc == WD_MAX) begin
                        wd    <= wd_inc;
                        ack_q <= gnt_q;
                        err_q <= 1'b1;
                        state <= ACK;
                    end else begin
                        wd <= wd_inc;
                    end
                end
                ACK: begin
                    ack_q  <= '0;
                    err_q  <= 1'b0;
                    gnt_q  <= '0;
                    busy_q <= 1'b0;
                    ptr    <= next_ptr;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt           = gnt_q;
    assign bus.ack           = ack_q;
    assign bus.err           = err_q;
    assign bus.busy          = busy_q;
    assign bus.uart_din      = din_q;
    assign bus.uart_tx_start = start_q;

endmodule
